// File: rtl/row_frame_buffer.sv
// Double-buffered frame store: a colour-sample stream fills the back buffer while the
// display controller reads whole rows from the front buffer; buffers swap on row-address wrap.
module row_frame_buffer #(
  parameter int unsigned COLOR_BITS    = 8,
  parameter int unsigned COL_ADDR_BITS = 6,
  parameter int unsigned ROW_ADDR_BITS = 4,
  parameter int unsigned COLOR_COUNT   = 3,
  localparam int unsigned ROW_ELEM      = 2 ** COL_ADDR_BITS,
  localparam int unsigned COL_ELEM      = 2 ** ROW_ADDR_BITS,
  localparam int unsigned ROW_DAT_WIDTH = ROW_ELEM * COLOR_BITS * COLOR_COUNT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  input  logic                     wr_sof,
  input  logic [COLOR_BITS-1:0]    wr_data,
  output logic                     wr_ready,
  input  logic [ROW_ADDR_BITS-1:0] row_addr,
  output logic [ROW_DAT_WIDTH-1:0] row_out,
  output logic                     front_sel,
  output logic                     frame_swap
);

  localparam int unsigned ColorW = (COLOR_COUNT > 1) ? $clog2(COLOR_COUNT) : 1;
  localparam int unsigned LsbW   = (ROW_DAT_WIDTH > 1) ? $clog2(ROW_DAT_WIDTH) : 1;
  localparam logic [ColorW-1:0] LastColor = ColorW'(COLOR_COUNT - 1);

  typedef enum logic [1:0] {StIdle, StFill, StPending} state_e;

  state_e                   state_q, state_d;
  logic [ColorW-1:0]        col_q, col_d, a_col;
  logic [COL_ADDR_BITS-1:0] pix_q, pix_d, a_pix;
  logic [ROW_ADDR_BITS-1:0] row_q, row_d, a_row;
  logic [ROW_ADDR_BITS-1:0] row_addr_q;
  logic [ROW_DAT_WIDTH-1:0] row_out_q;
  logic                     wr_ready_q, front_sel_q, frame_swap_q, blank_q;
  logic                     xfer, wrap, swap, we, last, col_last;
  logic [LsbW-1:0]          wr_lsb;

  logic [ROW_DAT_WIDTH-1:0] mem_q [2][COL_ELEM];

  assign xfer = wr_valid & wr_ready_q;
  assign wrap = (row_addr_q == '1) && (row_addr == '0);
  assign swap = (state_q == StPending) && wrap;

  // A start-of-frame sample always lands at element 0, whatever the counters hold.
  assign a_col    = wr_sof ? '0 : col_q;
  assign a_pix    = wr_sof ? '0 : pix_q;
  assign a_row    = wr_sof ? '0 : row_q;
  assign col_last = (a_col == LastColor);
  assign last     = col_last && (a_pix == '1) && (a_row == '1);
  assign wr_lsb   = LsbW'((COLOR_COUNT * 32'(a_pix) + 32'(a_col)) * COLOR_BITS);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    pix_d   = pix_q;
    row_d   = row_q;
    we      = 1'b0;
    unique case (state_q)
      StIdle, StFill: begin
        if (xfer && (wr_sof || (state_q == StFill))) begin
          we      = 1'b1;
          state_d = last ? StPending : StFill;
          col_d   = col_last ? '0 : a_col + ColorW'(1);
          pix_d   = col_last ? a_pix + COL_ADDR_BITS'(1) : a_pix;
          row_d   = (col_last && (a_pix == '1)) ? a_row + ROW_ADDR_BITS'(1) : a_row;
        end
      end
      StPending: begin
        if (swap) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      col_q        <= '0;
      pix_q        <= '0;
      row_q        <= '0;
      row_addr_q   <= '0;
      wr_ready_q   <= 1'b0;
      front_sel_q  <= 1'b0;
      frame_swap_q <= 1'b0;
      blank_q      <= 1'b1;
      row_out_q    <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      pix_q        <= pix_d;
      row_q        <= row_d;
      row_addr_q   <= row_addr;
      wr_ready_q   <= (state_d != StPending);
      frame_swap_q <= swap;
      if (swap) begin
        front_sel_q <= ~front_sel_q;
        blank_q     <= 1'b0;
      end
      // Read uses the pre-swap selection, so the swap-cycle row still comes from the old frame.
      row_out_q <= blank_q ? '0 : mem_q[front_sel_q][row_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[~front_sel_q][a_row][wr_lsb +: COLOR_BITS] <= wr_data;
  end

  assign wr_ready   = wr_ready_q;
  assign row_out    = row_out_q;
  assign front_sel  = front_sel_q;
  assign frame_swap = frame_swap_q;

endmodule

// File: tb/tb_row_frame_buffer.sv
// Directed bench for row_frame_buffer: a reference model of the two frame buffers feeds a
// scoreboard of expected row_out words, alongside explicit checks of the key scenarios.
module tb_row_frame_buffer;

  localparam int unsigned W     = 96;
  localparam int unsigned ROWS  = 4;
  localparam int          ELEMS = 12;
  localparam int          FRAME = 48;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_valid = 1'b0;
  logic         wr_sof = 1'b0;
  logic [7:0]   wr_data = '0;
  logic [1:0]   row_addr = '0;
  logic         wr_ready, front_sel, frame_swap;
  logic [W-1:0] row_out;

  always #5 clk = ~clk;

  row_frame_buffer #(
    .COLOR_BITS   (8),
    .COL_ADDR_BITS(2),
    .ROW_ADDR_BITS(2),
    .COLOR_COUNT  (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_sof    (wr_sof),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .row_addr  (row_addr),
    .row_out   (row_out),
    .front_sel (front_sel),
    .frame_swap(frame_swap)
  );

  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] sb_q[$];
  logic [W-1:0] m_disp[ROWS];
  logic [W-1:0] m_back[ROWS];
  logic         m_blank, m_front, m_pending, m_filling, m_ready;
  int           m_idx;
  logic [1:0]   m_prev_ra, last_ra;
  int           ra_cnt;
  bit           hold_ra;
  int           swaps_seen, dut_swaps;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_valid = 1'b0; wr_sof = 1'b0; row_addr = '0;
    #1;
    chk("rst_wr_ready", W'(wr_ready), W'(0));
    chk("rst_row_out", row_out, '0);
    chk("rst_front_sel", W'(front_sel), W'(0));
    chk("rst_frame_swap", W'(frame_swap), W'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_blank = 1'b1; m_front = 1'b0; m_pending = 1'b0; m_filling = 1'b0; m_ready = 1'b0;
    m_idx = 0; m_prev_ra = '0; ra_cnt = 0; sb_q.delete();
  endtask

  // One clock cycle: drive inputs, update the model, compare registered outputs after the edge.
  task automatic cyc(input logic v, input logic s, input logic [7:0] d, output logic acc);
    logic [1:0]   ra;
    logic         exp_swap;
    logic [W-1:0] exp_row;
    logic [W-1:0] tmp[ROWS];
    int           sh;
    ra = hold_ra ? 2'd1 : 2'(ra_cnt);
    ra_cnt++;
    wr_valid = v; wr_sof = s; wr_data = d; row_addr = ra;
    chk("wr_ready", W'(wr_ready), W'(m_ready));
    sb_q.push_back(m_blank ? '0 : m_disp[ra]);
    exp_swap = m_pending && (m_prev_ra == 2'd3) && (ra == 2'd0);
    acc = v && m_ready;
    if (acc && (s || m_filling)) begin
      if (s) m_idx = 0;
      sh = (m_idx % ELEMS) * 8;
      m_back[2'(m_idx / ELEMS)] = (m_back[2'(m_idx / ELEMS)] & ~(W'(8'hFF) << sh)) |
                                  (W'(d) << sh);
      m_idx++;
      m_filling = 1'b1;
      if (m_idx == FRAME) begin
        m_filling = 1'b0;
        m_pending = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    m_prev_ra = ra;
    last_ra   = ra;
    if (exp_swap) begin
      m_front = ~m_front; m_blank = 1'b0; m_pending = 1'b0;
      tmp = m_disp; m_disp = m_back; m_back = tmp;
      swaps_seen++;
    end
    m_ready = !m_pending;
    if (frame_swap === 1'b1) dut_swaps++;
    chk("frame_swap", W'(frame_swap), W'(exp_swap));
    chk("front_sel", W'(front_sel), W'(m_front));
    exp_row = sb_q.pop_front();
    chk("row_out", row_out, exp_row);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, acc);
  endtask

  task automatic send(input logic [7:0] base, input bit incr, input bit sof_first,
                      input int n, output int stalls);
    logic acc;
    int   tries;
    stalls = 0;
    for (int k = 0; k < n; k++) begin
      tries = 0;
      acc   = 1'b0;
      while (!acc && tries < 16) begin
        cyc(1'b1, sof_first && (k == 0), incr ? base + 8'(k) : base, acc);
        if (!acc) stalls++;
        tries++;
      end
      if (!acc) begin
        chk("accept_timeout", W'(acc), W'(1));
        return;
      end
    end
    wr_valid = 1'b0; wr_sof = 1'b0;
  endtask

  task automatic wait_swap(input int target);
    for (int i = 0; i < 16 && swaps_seen < target; i++) idle(1);
    chk("swap_model", W'(swaps_seen), W'(target));
    chk("swap_total", W'(dut_swaps), W'(swaps_seen));
  endtask

  task automatic wait_ra(input logic [1:0] ra);
    for (int i = 0; i < 8 && last_ra != ra; i++) idle(1);
  endtask

  initial begin
    int   stalls;
    logic has_ff;
    hold_ra = 0; swaps_seen = 0; dut_swaps = 0; last_ra = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      m_disp[r] = '0;
      m_back[r] = '0;
    end

    // Blank display after reset while rows cycle.
    do_reset();
    idle(8);

    // First frame 0x00..0x2F, swap on the first wrap, then row 0 content.
    send(8'h00, 1'b1, 1'b1, FRAME, stalls);
    wait_swap(1);
    wait_ra(2'd3);
    idle(1);
    chk("frame1_row0", row_out, 96'h0B0A09080706050403020100);
    idle(4);

    // Back-to-back frames: the second must stall while the first waits for its swap.
    send(8'h80, 1'b1, 1'b1, FRAME, stalls);
    send(8'h40, 1'b1, 1'b1, FRAME, stalls);
    chk("pending_stall", W'(stalls > 0), W'(1));
    wait_swap(3);
    idle(4);

    // Aborted partial frame followed by a full constant frame.
    send(8'h11, 1'b0, 1'b1, 20, stalls);
    send(8'hA5, 1'b0, 1'b1, FRAME, stalls);
    wait_swap(4);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("all_a5", row_out, {12{8'hA5}});
    end

    // Samples without start-of-frame in idle are dropped.
    send(8'hFF, 1'b0, 1'b0, 5, stalls);
    send(8'h60, 1'b1, 1'b1, FRAME, stalls);
    wait_swap(5);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      has_ff = 1'b0;
      for (int b = 0; b < ELEMS; b++) if (row_out[b*8 +: 8] == 8'hFF) has_ff = 1'b1;
      chk("no_ff", W'(has_ff), W'(0));
    end

    // Reset while a completed frame is pending: frame is abandoned.
    hold_ra = 1;
    send(8'h33, 1'b0, 1'b1, FRAME, stalls);
    idle(3);
    chk("pending_ready_low", W'(wr_ready), W'(0));
    do_reset();
    hold_ra = 0;
    swaps_seen = 0; dut_swaps = 0;
    idle(12);
    chk("post_reset_swaps", W'(dut_swaps), W'(0));
    chk("post_reset_front", W'(front_sel), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
